fp_register_file_mp: RTL and testbench

FP_REGISTER_FILE_MP -- requirements
Module: fp_register_file_mp

---
 rtl/fp_rf_pkg.sv | 25 ++
 rtl/fp_nanbox_check.sv | 23 ++
 rtl/fp_register_file_mp.sv | 132 +++++++++++++
 tb/tb_fp_register_file_mp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_rf_pkg.sv
// Shared constants for the FP register file: CSR selector encoding, flag bit
// positions, the canonical single-precision NaN and fcsr field layout.
package fp_rf_pkg;

    typedef enum logic [1:0] {
        CsrNone   = 2'b00,
        CsrFflags = 2'b01,
        CsrFrm    = 2'b10,
        CsrFcsr   = 2'b11
    } csr_sel_e;

    localparam int unsigned FlagNx = 0;
    localparam int unsigned FlagUf = 1;
    localparam int unsigned FlagOf = 2;
    localparam int unsigned FlagDz = 3;
    localparam int unsigned FlagNv = 4;

    localparam logic [31:0] CanonicalNan = 32'h7FC0_0000;

    localparam int unsigned FcsrFflagsLsb = 0;
    localparam int unsigned FcsrFflagsMsb = 4;
    localparam int unsigned FcsrFrmLsb    = 5;
    localparam int unsigned FcsrFrmMsb    = 7;

endpackage

// File: rtl/fp_nanbox_check.sv
// Single-precision read filter: with FLEN=64, an improperly NaN-boxed value read
// as single precision is replaced by the boxed canonical NaN.
module fp_nanbox_check
    import fp_rf_pkg::*;
#(
    parameter int unsigned FLEN = 32
) (
    input  logic [FLEN-1:0] raw,
    input  logic            sp,
    output logic [FLEN-1:0] data_out
);

    if (FLEN == 64) begin : g_box
        logic boxed;
        assign boxed    = &raw[FLEN-1:FLEN-32];
        assign data_out = (sp && !boxed) ? {32'hFFFF_FFFF, CanonicalNan} : raw;
    end else begin : g_nobox
        logic unused_sp;
        assign unused_sp = sp;
        assign data_out  = raw;
    end

endmodule

// File: rtl/fp_register_file_mp.sv
// Multi-port FP register file with fflags/frm CSRs and FS dirty tracking.
// Optional write-to-read bypass when FP_RF_BYPASS_EN is defined.
module fp_register_file_mp
    import fp_rf_pkg::*;
#(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned NREAD = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREAD*5-1:0]    rs_addr,
    input  logic [NREAD-1:0]      rs_sp,
    output logic [NREAD*FLEN-1:0] rs_data,
    input  logic                  wen,
    input  logic [4:0]            rd,
    input  logic [FLEN-1:0]       w_data,
    input  logic                  w_sp,
    input  logic                  flags_en,
    input  logic [4:0]            flags_in,
    input  logic                  csr_wen,
    input  logic [1:0]            csr_sel,
    input  logic [7:0]            csr_wdata,
    output logic [7:0]            csr_rdata,
    output logic [2:0]            frm,
    output logic [4:0]            fflags,
    output logic                  fs_dirty,
    input  logic                  fs_clean
);

    logic [FLEN-1:0] regs [32];
    logic [FLEN-1:0] wr_val;
    logic [2:0]      frm_q, frm_d;
    logic [4:0]      fflags_q, fflags_d;
    logic            dirty_q, dirty_d;
    logic            dirty_set;
    csr_sel_e        sel;

    assign sel = csr_sel_e'(csr_sel);

    // Single-precision writes are NaN-boxed into the upper half
    if (FLEN == 64) begin : g_wbox
        assign wr_val = w_sp ? {32'hFFFF_FFFF, w_data[31:0]} : w_data;
    end else begin : g_wnobox
        logic unused_w_sp;
        assign unused_w_sp = w_sp;
        assign wr_val      = w_data;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wen) begin
            regs[rd] <= wr_val;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [4:0]      addr;
        logic [FLEN-1:0] raw;
        assign addr = rs_addr[5*i +: 5];
`ifdef FP_RF_BYPASS_EN
        assign raw = (wen && (rd == addr)) ? wr_val : regs[addr];
`else
        assign raw = regs[addr];
`endif
        fp_nanbox_check #(
            .FLEN(FLEN)
        ) u_nanbox (
            .raw      (raw),
            .sp       (rs_sp[i]),
            .data_out (rs_data[FLEN*i +: FLEN])
        );
    end

    always_comb begin
        fflags_d = fflags_q;
        frm_d    = frm_q;
        if (flags_en) begin
            fflags_d = fflags_q | flags_in;
        end
        // CSR writes come last so they override same-cycle flag accrual
        if (csr_wen) begin
            case (sel)
                CsrFflags: fflags_d = csr_wdata[FcsrFflagsMsb:FcsrFflagsLsb];
                CsrFrm:    frm_d    = csr_wdata[2:0];
                CsrFcsr: begin
                    fflags_d = csr_wdata[FcsrFflagsMsb:FcsrFflagsLsb];
                    frm_d    = csr_wdata[FcsrFrmMsb:FcsrFrmLsb];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dirty_set = wen || (flags_en && (flags_in != 5'd0)) || (csr_wen && (sel != CsrNone));
        dirty_d   = dirty_q;
        if (dirty_set) begin
            dirty_d = 1'b1;
        end else if (fs_clean) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            frm_q    <= '0;
            fflags_q <= '0;
            dirty_q  <= 1'b0;
        end else begin
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
            dirty_q  <= dirty_d;
        end
    end

    always_comb begin
        case (sel)
            CsrFflags: csr_rdata = {3'b000, fflags_q};
            CsrFrm:    csr_rdata = {5'b00000, frm_q};
            CsrFcsr:   csr_rdata = {frm_q, fflags_q};
            default:   csr_rdata = 8'h00;
        endcase
    end

    assign frm      = frm_q;
    assign fflags   = fflags_q;
    assign fs_dirty = dirty_q;

endmodule

// File: tb/tb_fp_register_file_mp.sv
// Directed bench for fp_register_file_mp at FLEN=64, NREAD=3.
module tb_fp_register_file_mp;

    localparam int unsigned FLEN  = 64;
    localparam int unsigned NREAD = 3;

    logic                  CLK;
    logic                  nRST;
    logic [NREAD*5-1:0]    rs_addr;
    logic [NREAD-1:0]      rs_sp;
    logic [NREAD*FLEN-1:0] rs_data;
    logic                  wen;
    logic [4:0]            rd;
    logic [FLEN-1:0]       w_data;
    logic                  w_sp;
    logic                  flags_en;
    logic [4:0]            flags_in;
    logic                  csr_wen;
    logic [1:0]            csr_sel;
    logic [7:0]            csr_wdata;
    logic [7:0]            csr_rdata;
    logic [2:0]            frm;
    logic [4:0]            fflags;
    logic                  fs_dirty;
    logic                  fs_clean;

    int checks = 0;
    int errors = 0;

    fp_register_file_mp #(
        .FLEN  (FLEN),
        .NREAD (NREAD)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .rs_addr   (rs_addr),
        .rs_sp     (rs_sp),
        .rs_data   (rs_data),
        .wen       (wen),
        .rd        (rd),
        .w_data    (w_data),
        .w_sp      (w_sp),
        .flags_en  (flags_en),
        .flags_in  (flags_in),
        .csr_wen   (csr_wen),
        .csr_sel   (csr_sel),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .frm       (frm),
        .fflags    (fflags),
        .fs_dirty  (fs_dirty),
        .fs_clean  (fs_clean)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        wsp;
        logic        rsp;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_all(input logic [4:0] a, input logic sp);
        rs_addr = {NREAD{a}};
        rs_sp   = {NREAD{sp}};
        #1;
    endtask

    task automatic chk_ports(input string name, input logic [63:0] exp);
        for (int p = 0; p < NREAD; p++) begin
            chk($sformatf("%s port%0d", name, p), rs_data[FLEN*p +: FLEN], exp);
        end
    endtask

    initial begin
        vecs[0] = '{5'd3,  64'h0000_0000_3F80_0000, 1'b1, 1'b1, 64'hFFFF_FFFF_3F80_0000};
        vecs[1] = '{5'd3,  64'h4000_0000_0000_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_7FC0_0000};
        vecs[2] = '{5'd3,  64'h4000_0000_0000_0000, 1'b0, 1'b0, 64'h4000_0000_0000_0000};
        vecs[3] = '{5'd0,  64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[4] = '{5'd31, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 64'hFFFF_FFFF_9ABC_DEF0};
        vecs[5] = '{5'd31, 64'hFFFF_FFFF_0000_0001, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001};
        vecs[6] = '{5'd15, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1, 64'hFFFF_FFFF_7FC0_0000};

        nRST = 1'b0; rs_addr = '0; rs_sp = '0; wen = 1'b0; rd = '0; w_data = '0; w_sp = 1'b0;
        flags_en = 1'b0; flags_in = '0; csr_wen = 1'b0; csr_sel = 2'b00; csr_wdata = '0;
        fs_clean = 1'b0;
        step();
        step();
        nRST = 1'b1;
        step();

        // Reset state on every register and port
        for (int a = 0; a < 32; a++) begin
            read_all(5'(a), 1'b0);
            chk_ports($sformatf("reset f%0d", a), 64'd0);
        end
        chk("reset frm", 64'(frm), 64'd0);
        chk("reset fflags", 64'(fflags), 64'd0);
        chk("reset fs_dirty", 64'(fs_dirty), 64'd0);

        // Zero flags and a no-op CSR write must not dirty the state
        flags_en = 1'b1; flags_in = 5'd0;
        step();
        flags_en = 1'b0;
        csr_wen = 1'b1; csr_sel = 2'b00; csr_wdata = 8'hFF;
        step();
        csr_wen = 1'b0;
        chk("no-op dirty", 64'(fs_dirty), 64'd0);
        chk("no-op frm", 64'(frm), 64'd0);
        chk("no-op fflags", 64'(fflags), 64'd0);

        // Same-cycle read of the register being written
        wen = 1'b1; rd = 5'd7; w_data = 64'h0000_0000_1234_5678; w_sp = 1'b0;
        rs_addr = {5'd0, 5'd0, 5'd7}; rs_sp = '0;
        #1;
`ifdef FP_RF_BYPASS_EN
        chk("bypass f7", rs_data[FLEN-1:0], 64'h0000_0000_1234_5678);
`else
        chk("bypass f7", rs_data[FLEN-1:0], 64'd0);
`endif
        step();
        wen = 1'b0;
        read_all(5'd7, 1'b0);
        chk_ports("f7 after write", 64'h0000_0000_1234_5678);
        chk("dirty after write", 64'(fs_dirty), 64'd1);

        // Set wins over clean, then clean alone clears
        fs_clean = 1'b1; wen = 1'b1; rd = 5'd9; w_data = 64'd1;
        step();
        wen = 1'b0;
        chk("clean+wen dirty", 64'(fs_dirty), 64'd1);
        step();
        fs_clean = 1'b0;
        chk("clean alone dirty", 64'(fs_dirty), 64'd0);

        // Table-driven write then read, including NaN-box cases
        for (int v = 0; v < 7; v++) begin
            wen = 1'b1; rd = vecs[v].rd; w_data = vecs[v].data; w_sp = vecs[v].wsp;
            step();
            wen = 1'b0; w_sp = 1'b0;
            read_all(vecs[v].rd, vecs[v].rsp);
            chk_ports($sformatf("vec%0d", v), vecs[v].exp);
        end
        read_all(5'd9, 1'b0);
        chk_ports("f9 retained", 64'd1);

        // Sticky flag accrual
        flags_en = 1'b1; flags_in = 5'h01;
        step();
        flags_in = 5'h10;
        step();
        flags_en = 1'b0; flags_in = '0;
        chk("accrue fflags", 64'(fflags), 64'h11);
        csr_sel = 2'b01;
        #1;
        chk("rdata fflags", 64'(csr_rdata), 64'h11);

        // CSR write beats simultaneous accrual
        csr_wen = 1'b1; csr_sel = 2'b01; csr_wdata = 8'h00;
        flags_en = 1'b1; flags_in = 5'h04;
        step();
        csr_wen = 1'b0; flags_en = 1'b0; flags_in = '0;
        chk("csr beats flags", 64'(fflags), 64'h00);

        csr_wen = 1'b1; csr_sel = 2'b10; csr_wdata = 8'hFA;
        step();
        csr_wen = 1'b0;
        chk("frm write", 64'(frm), 64'd2);
        chk("frm write fflags kept", 64'(fflags), 64'd0);
        flags_en = 1'b1; flags_in = 5'h03;
        step();
        flags_en = 1'b0; flags_in = '0;

        // fcsr write: read value in the same cycle is the old one
        csr_wen = 1'b1; csr_sel = 2'b11; csr_wdata = 8'hE5;
        #1;
        chk("fcsr rdata old", 64'(csr_rdata), 64'h43);
        step();
        csr_wen = 1'b0;
        chk("fcsr frm", 64'(frm), 64'd7);
        chk("fcsr fflags", 64'(fflags), 64'h05);
        chk("fcsr rdata new", 64'(csr_rdata), 64'hE5);
        csr_sel = 2'b10;
        #1;
        chk("frm rdata", 64'(csr_rdata), 64'h07);
        csr_wen = 1'b1; csr_sel = 2'b11; csr_wdata = 8'hC0;
        step();
        csr_wen = 1'b0;
        chk("frm reserved 6", 64'(frm), 64'd6);
        chk("fcsr fflags clear", 64'(fflags), 64'd0);

        // Asynchronous reset away from any clock edge
        #2;
        nRST = 1'b0;
        #1;
        read_all(5'd31, 1'b0);
        chk_ports("async reset f31", 64'd0);
        chk("async reset frm", 64'(frm), 64'd0);
        chk("async reset dirty", 64'(fs_dirty), 64'd0);

        // Write during reset is lost; first write afterwards lands
        wen = 1'b1; rd = 5'd5; w_data = 64'hAAAA_5555_AAAA_5555;
        step();
        wen = 1'b0;
        nRST = 1'b1;
        read_all(5'd5, 1'b0);
        chk_ports("write in reset lost", 64'd0);
        wen = 1'b1;
        step();
        wen = 1'b0;
        read_all(5'd5, 1'b0);
        chk_ports("first write after reset", 64'hAAAA_5555_AAAA_5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
